// File: rtl/puf_eval_sequencer.sv
// Sequences PUF reset, trigger and settle for one or more evaluations of a latched challenge,
// then presents the majority-voted XOR response with a valid/ack handshake.
module puf_eval_sequencer #(
    parameter int unsigned CHALLENGE_WIDTH  = 64,
    parameter int unsigned PDL_CONFIG_WIDTH = 64,
    parameter int unsigned RESPONSE_WIDTH   = 6,
    parameter int unsigned RESET_CYCLES     = 2,
    parameter int unsigned SETTLE_CYCLES    = 15,
    parameter int unsigned REPEAT_WIDTH     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [CHALLENGE_WIDTH-1:0]  challenge_in,
    input  logic [PDL_CONFIG_WIDTH-1:0] pdl_config_in,
    input  logic [REPEAT_WIDTH-1:0]     repeat_count,
    output logic                        busy,
    output logic [CHALLENGE_WIDTH-1:0]  puf_challenge,
    output logic [PDL_CONFIG_WIDTH-1:0] puf_pdl_config,
    output logic                        puf_trigger,
    output logic                        puf_reset,
    input  logic [RESPONSE_WIDTH-1:0]   puf_raw_response,
    input  logic                        puf_xor_response,
    output logic                        result_valid,
    input  logic                        result_ack,
    output logic [RESPONSE_WIDTH-1:0]   result_raw,
    output logic                        result_xor,
    output logic [REPEAT_WIDTH-1:0]     result_ones,
    output logic [REPEAT_WIDTH-1:0]     result_count
);

    localparam int unsigned TimerMax   = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES
                                                                       : SETTLE_CYCLES;
    localparam int unsigned TimerWidth = (TimerMax > 1) ? $clog2(TimerMax) : 1;

    typedef enum logic [2:0] {StIdle, StPrst, StArm, StSample, StDone} state_e;

    state_e                  state_q, state_d;
    logic [TimerWidth-1:0]   timer_q, timer_d;
    logic [REPEAT_WIDTH-1:0] reps_q;
    logic [REPEAT_WIDTH-1:0] ones_next, count_next;

    // result_ones/result_count double as the running accumulators.
    assign ones_next  = result_ones + REPEAT_WIDTH'(puf_xor_response);
    assign count_next = result_count + REPEAT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (start) state_d = StPrst;
            end
            StPrst: begin
                if (timer_q == TimerWidth'(RESET_CYCLES - 1)) begin
                    state_d = StArm;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerWidth'(1);
                end
            end
            StArm: begin
                if (timer_q == TimerWidth'(SETTLE_CYCLES - 1)) begin
                    state_d = StSample;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerWidth'(1);
                end
            end
            StSample: begin
                timer_d = '0;
                state_d = (count_next == reps_q) ? StDone : StPrst;
            end
            StDone: begin
                if (result_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            reps_q         <= '0;
            busy           <= 1'b0;
            puf_trigger    <= 1'b0;
            puf_reset      <= 1'b1;
            result_valid   <= 1'b0;
            puf_challenge  <= '0;
            puf_pdl_config <= '0;
            result_raw     <= '0;
            result_xor     <= 1'b0;
            result_ones    <= '0;
            result_count   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            // Outputs are registered from the next state so they align with state_q.
            busy         <= (state_d != StIdle);
            puf_trigger  <= (state_d == StArm);
            puf_reset    <= (state_d == StIdle) || (state_d == StPrst) || (state_d == StDone);
            result_valid <= (state_d == StDone);

            if (state_q == StIdle && start) begin
                puf_challenge  <= challenge_in;
                puf_pdl_config <= pdl_config_in;
                reps_q         <= (repeat_count == '0) ? REPEAT_WIDTH'(1) : repeat_count;
                result_ones    <= '0;
                result_count   <= '0;
                result_xor     <= 1'b0;
            end

            if (state_q == StSample) begin
                result_raw   <= puf_raw_response;
                result_ones  <= ones_next;
                result_count <= count_next;
                // Strict majority; a tie resolves to 0.
                result_xor   <= ({ones_next, 1'b0} > {1'b0, count_next});
            end
        end
    end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Randomized self-checking bench for puf_eval_sequencer with a per-evaluation PUF response stub.
module tb_puf_eval_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] challenge_in;
    logic [63:0] pdl_config_in;
    logic [7:0]  repeat_count;
    logic        busy;
    logic [63:0] puf_challenge;
    logic [63:0] puf_pdl_config;
    logic        puf_trigger;
    logic        puf_reset;
    logic [5:0]  puf_raw_response;
    logic        puf_xor_response;
    logic        result_valid;
    logic        result_ack;
    logic [5:0]  result_raw;
    logic        result_xor;
    logic [7:0]  result_ones;
    logic [7:0]  result_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Stub: evaluation k (1-based, counted by trigger pulses since base) returns seq[k-1].
    logic       xor_seq [0:255];
    logic [5:0] raw_seq [0:255];
    int         n_trig = 0;
    int         base   = 0;
    logic       trig_prev = 1'b0;
    int         idx;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (puf_trigger && !trig_prev) n_trig = n_trig + 1;
        trig_prev = puf_trigger;
    end

    always_comb begin
        idx = n_trig - base - 1;
        if (idx < 0 || idx > 255) idx = 0;
        puf_xor_response = xor_seq[idx];
        puf_raw_response = raw_seq[idx];
    end

    puf_eval_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .challenge_in     (challenge_in),
        .pdl_config_in    (pdl_config_in),
        .repeat_count     (repeat_count),
        .busy             (busy),
        .puf_challenge    (puf_challenge),
        .puf_pdl_config   (puf_pdl_config),
        .puf_trigger      (puf_trigger),
        .puf_reset        (puf_reset),
        .puf_raw_response (puf_raw_response),
        .puf_xor_response (puf_xor_response),
        .result_valid     (result_valid),
        .result_ack       (result_ack),
        .result_raw       (result_raw),
        .result_xor       (result_xor),
        .result_ones      (result_ones),
        .result_count     (result_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction; hold>0 keeps ack low that many DONE cycles while pulsing start,
    // then asserts start together with ack.
    task automatic run_eval(input logic [63:0] ch, input logic [63:0] cfg, input logic [7:0] rc,
                            input int hold, input string tag);
        int         reps, exp_ones, lat, trig_cyc, rst_cyc, unstable, bad;
        logic       exp_xor;
        logic [5:0] exp_raw;
        reps     = (rc == 0) ? 1 : int'(rc);
        exp_ones = 0;
        for (int i = 0; i < reps; i++) exp_ones += int'(xor_seq[i]);
        exp_raw  = raw_seq[reps-1];
        exp_xor  = (2 * exp_ones > reps);
        lat = 0; trig_cyc = 0; rst_cyc = 0; unstable = 0; bad = 0;

        check_eq({tag, " idle_before"}, {63'd0, busy}, 64'd0);
        base          = n_trig;
        challenge_in  = ch;
        pdl_config_in = cfg;
        repeat_count  = rc;
        start         = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
        challenge_in  = ~ch;
        pdl_config_in = ~cfg;
        while (!result_valid && lat < reps * 18 + 40) begin
            if (puf_challenge !== ch || puf_pdl_config !== cfg) unstable++;
            if (busy && puf_reset) rst_cyc++;
            if (puf_trigger) trig_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, " latency"}, 64'(lat), 64'(reps * 18));
        check_eq({tag, " valid"}, {63'd0, result_valid}, 64'd1);
        check_eq({tag, " raw"}, {58'd0, result_raw}, {58'd0, exp_raw});
        check_eq({tag, " xor"}, {63'd0, result_xor}, {63'd0, exp_xor});
        check_eq({tag, " ones"}, {56'd0, result_ones}, 64'(exp_ones));
        check_eq({tag, " count"}, {56'd0, result_count}, 64'(reps));
        check_eq({tag, " trig_pulses"}, 64'(n_trig - base), 64'(reps));
        check_eq({tag, " trig_cycles"}, 64'(trig_cyc), 64'(reps * 15));
        check_eq({tag, " rst_cycles"}, 64'(rst_cyc), 64'(reps * 2));
        check_eq({tag, " ch_stable"}, 64'(unstable), 64'd0);
        check_eq({tag, " done_rst"}, {62'd0, puf_reset, puf_trigger}, 64'd2);

        for (int h = 0; h < hold; h++) begin
            start = h[0];
            @(posedge clk); #1;
            if (!result_valid || !busy || puf_trigger || !puf_reset
                || result_count !== 8'(reps)) bad++;
        end
        if (hold > 0) check_eq({tag, " hold"}, 64'(bad), 64'd0);

        start      = (hold > 0);
        result_ack = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        result_ack = 1'b0;
        check_eq({tag, " ack_valid"}, {62'd0, result_valid, busy}, 64'd0);
        check_eq({tag, " keep_res"}, {42'd0, result_raw, result_xor, result_ones, result_count},
                 {42'd0, exp_raw, exp_xor, 8'(exp_ones), 8'(reps)});
        @(posedge clk); #1;
        check_eq({tag, " stay_idle"}, {62'd0, busy, puf_trigger}, 64'd0);
    endtask

    initial begin
        int               rc;
        logic [63:0]      rch;
        start         = 1'b0;
        result_ack    = 1'b0;
        challenge_in  = '0;
        pdl_config_in = '0;
        repeat_count  = '0;
        for (int i = 0; i < 256; i++) begin
            xor_seq[i] = 1'b0;
            raw_seq[i] = 6'd0;
        end

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_ctrl", {60'd0, puf_reset, puf_trigger, busy, result_valid}, 64'h8);
        check_eq("rst_res", {48'd0, result_count, result_ones}, 64'd0);
        check_eq("rst_rawxor", {57'd0, result_raw, result_xor}, 64'd0);
        check_eq("rst_ch", puf_challenge | puf_pdl_config, 64'd0);

        xor_seq[0] = 1'b1; raw_seq[0] = 6'h2B;
        run_eval(64'hA5A5_0000_FFFF_1234, 64'h0F, 8'd1, 0, "single");

        xor_seq[0] = 1'b0; raw_seq[0] = 6'h15;
        run_eval(64'h1234_5678_9ABC_DEF0, 64'h33, 8'd0, 0, "rep0");

        xor_seq[0] = 1; xor_seq[1] = 0; xor_seq[2] = 1; xor_seq[3] = 1; xor_seq[4] = 0;
        for (int i = 0; i < 5; i++) raw_seq[i] = 6'(i + 7);
        run_eval(64'hDEAD_BEEF_0000_0001, 64'hF0, 8'd5, 0, "rep5");

        xor_seq[3] = 0;
        run_eval(64'hCAFE_F00D_CAFE_F00D, 64'h55, 8'd4, 10, "tie4");

        // Abort during ARM of a 3-repeat run.
        base          = n_trig;
        challenge_in  = 64'h0BAD_0BAD_0BAD_0BAD;
        pdl_config_in = 64'h77;
        repeat_count  = 8'd3;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("abort_in_arm", {63'd0, puf_trigger}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_ctrl", {60'd0, puf_reset, puf_trigger, busy, result_valid}, 64'h8);
        check_eq("abort_cnt", {56'd0, result_count}, 64'd0);
        xor_seq[0] = 1; xor_seq[1] = 1; xor_seq[2] = 0;
        run_eval(64'h1111_2222_3333_4444, 64'h99, 8'd3, 0, "after_abort");

        for (int t = 0; t < 6; t++) begin
            rc  = $urandom_range(0, 7);
            rch = {$urandom, $urandom};
            for (int i = 0; i < 8; i++) begin
                xor_seq[i] = 1'($urandom);
                raw_seq[i] = 6'($urandom);
            end
            run_eval(rch, {$urandom, $urandom}, 8'(rc), $urandom_range(0, 3), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
